// File: rtl/mdu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mdu_issue_ctrl
// Description : Execute-stage requester for the multiply/divide unit. Resolves
//               RISC-V divide corner cases locally, issues all other ops over
//               req/gnt/rvalid and emits a single writeback pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_issue_ctrl #(
    parameter int WORD_SIZE = 32,
    parameter int RD_WIDTH  = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   dec_valid_i,
    output logic                   dec_ready_o,
    input  logic [2:0]             dec_funct3_i,
    input  logic [WORD_SIZE-1:0]   dec_rs1_i,
    input  logic [WORD_SIZE-1:0]   dec_rs2_i,
    input  logic [RD_WIDTH-1:0]    dec_rd_i,
    input  logic                   flush_i,
    output logic                   mdu_req_o,
    input  logic                   mdu_gnt_i,
    output logic [2:0]             mdu_operator_o,
    output logic [WORD_SIZE-1:0]   mdu_operand_a_o,
    output logic [WORD_SIZE-1:0]   mdu_operand_b_o,
    input  logic                   mdu_rvalid_i,
    input  logic [2*WORD_SIZE-1:0] mdu_result_i,
    output logic                   wb_valid_o,
    output logic [RD_WIDTH-1:0]    wb_rd_o,
    output logic [WORD_SIZE-1:0]   wb_data_o,
    output logic                   busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_WB    = 3'd4
    } state_t;

    localparam logic [2:0] c_FN_MUL  = 3'd0;
    localparam logic [2:0] c_FN_DIV  = 3'd4;
    localparam logic [2:0] c_FN_DIVU = 3'd5;
    localparam logic [2:0] c_FN_REM  = 3'd6;
    localparam logic [2:0] c_FN_REMU = 3'd7;
    localparam logic [WORD_SIZE-1:0] c_MIN_INT = {1'b1, {(WORD_SIZE-1){1'b0}}};

    state_t                 r_state;
    logic [2:0]             r_op;
    logic [WORD_SIZE-1:0]   r_a;
    logic [WORD_SIZE-1:0]   r_b;
    logic [RD_WIDTH-1:0]    r_rd;
    logic [WORD_SIZE-1:0]   r_wb_data;
    logic [RD_WIDTH-1:0]    r_wb_rd;

    logic                   w_accept;
    logic                   w_rs2_zero;
    logic                   w_overflow;
    logic                   w_shortcut;
    logic [WORD_SIZE-1:0]   w_fix_data;
    logic                   w_low_half;
    logic [WORD_SIZE-1:0]   w_sel_result;

    assign w_accept   = (r_state == ST_IDLE) && !flush_i && dec_valid_i;
    assign w_rs2_zero = (dec_rs2_i == '0);
    assign w_overflow = (dec_rs1_i == c_MIN_INT) && (dec_rs2_i == '1);

    // Divide-by-zero and signed overflow have architecturally fixed results,
    // so they never reach the MDU.
    always_comb begin
        w_shortcut = 1'b0;
        w_fix_data = '0;
        case (dec_funct3_i)
            c_FN_DIV: begin
                if (w_rs2_zero) begin
                    w_shortcut = 1'b1;
                    w_fix_data = '1;
                end else if (w_overflow) begin
                    w_shortcut = 1'b1;
                    w_fix_data = dec_rs1_i;
                end
            end
            c_FN_DIVU: begin
                if (w_rs2_zero) begin
                    w_shortcut = 1'b1;
                    w_fix_data = '1;
                end
            end
            c_FN_REM: begin
                if (w_rs2_zero) begin
                    w_shortcut = 1'b1;
                    w_fix_data = dec_rs1_i;
                end else if (w_overflow) begin
                    w_shortcut = 1'b1;
                    w_fix_data = '0;
                end
            end
            c_FN_REMU: begin
                if (w_rs2_zero) begin
                    w_shortcut = 1'b1;
                    w_fix_data = dec_rs1_i;
                end
            end
            default: ;
        endcase
    end

    assign w_low_half   = (r_op == c_FN_MUL) || (r_op == c_FN_DIV) || (r_op == c_FN_DIVU);
    assign w_sel_result = w_low_half ? mdu_result_i[WORD_SIZE-1:0]
                                     : mdu_result_i[2*WORD_SIZE-1:WORD_SIZE];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_rd      <= '0;
            r_wb_data <= '0;
            r_wb_rd   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op <= dec_funct3_i;
                        r_a  <= dec_rs1_i;
                        r_b  <= dec_rs2_i;
                        r_rd <= dec_rd_i;
                        if (w_shortcut) begin
                            r_wb_data <= w_fix_data;
                            r_wb_rd   <= dec_rd_i;
                            r_state   <= ST_WB;
                        end else begin
                            r_state <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    // A granted request owes us a response even when killed.
                    if (flush_i) begin
                        r_state <= mdu_gnt_i ? ST_DRAIN : ST_IDLE;
                    end else if (mdu_gnt_i) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (flush_i) begin
                        r_state <= mdu_rvalid_i ? ST_IDLE : ST_DRAIN;
                    end else if (mdu_rvalid_i) begin
                        r_wb_data <= w_sel_result;
                        r_wb_rd   <= r_rd;
                        r_state   <= ST_WB;
                    end
                end
                ST_DRAIN: begin
                    if (mdu_rvalid_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WB: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dec_ready_o     = (r_state == ST_IDLE) && !flush_i;
    assign mdu_req_o       = (r_state == ST_REQ);
    assign mdu_operator_o  = r_op;
    assign mdu_operand_a_o = r_a;
    assign mdu_operand_b_o = r_b;
    assign wb_valid_o      = (r_state == ST_WB) && !flush_i;
    assign wb_rd_o         = r_wb_rd;
    assign wb_data_o       = r_wb_data;
    assign busy_o          = (r_state != ST_IDLE);

endmodule
`default_nettype wire
